// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared PS/2 host transmitter types, command codes and frame helper
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [3:0] LAST_BIT = 4'd10;

  // Frame layout on the wire, index = bit order: start, data LSB..MSB, odd parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and open-drain line bundle of the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;

  modport master (
    output tx_data, tx_start, ps2c_in, ps2d_in,
    input  busy, done, err, ps2c_oe, ps2d_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2c_in, ps2d_in,
    output busy, done, err, ps2c_oe, ps2d_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizers for ps2c/ps2d plus a registered ps2c falling-edge strobe
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_o,
  output logic ps2d_o,
  output logic ps2c_fe_o
);

  logic [1:0] c_sync_q;
  logic [1:0] d_sync_q;
  logic       c_prev_q;
  logic       fe_q;

  // Lines idle high, so the chain resets to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
      fe_q     <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      c_prev_q <= c_sync_q[1];
      fe_q     <= c_prev_q & ~c_sync_q[1];
    end
  end

  assign ps2c_o    = c_sync_q[1];
  assign ps2d_o    = d_sync_q[1];
  assign ps2c_fe_o = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with inhibit, RTS, bit clocking and ACK
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic         clk,
  input logic         reset,
  ps2_host_tx_if.slave bus
);

  localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [10:0]      shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic ps2c_s, ps2d_s, fe, timeout;

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .ps2c_i    (bus.ps2c_in),
    .ps2d_i    (bus.ps2d_in),
    .ps2c_o    (ps2c_s),
    .ps2d_o    (ps2d_s),
    .ps2c_fe_o (fe)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign timeout = (cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        dout_d = 1'b0;
        // The done/err cycle itself is not an accept slot; the next one is.
        if (bus.tx_start && !done_q && !err_q) begin
          shift_d = build_frame(bus.tx_data);
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          dout_d  = ~shift_q[0];
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RTS_LAST) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (fe) begin
          cnt_d    = '0;
          bitcnt_d = (bitcnt_q == LAST_BIT) ? bitcnt_q : bitcnt_q + 4'd1;
          dout_d   = ~shift_q[bitcnt_d];
          if (bitcnt_q == LAST_BIT - 4'd1) state_d = ST_ACK;
        end else if (timeout) begin
          dout_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        cnt_d  = cnt_q + 1'b1;
        dout_d = 1'b0;
        if (fe) begin
          cnt_d = '0;
          if (!ps2d_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = fe ? '0 : cnt_q + 1'b1;
        if (ps2c_s && ps2d_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout && !fe) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.ps2c_oe = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    bus.ps2d_oe = dout_q;
    bus.done    = done_q;
    bus.err     = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - device BFM and frame model bench for ps2_host_tx
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 40;
  localparam int RTS  = 8;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic bfm_c = 1'b0;
  logic bfm_d = 1'b0;

  int checks    = 0;
  int passes    = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;
  int last_fall = 0;

  ps2_host_tx_if bus ();

  assign bus.ps2c_in = ~(bus.ps2c_oe | bfm_c);
  assign bus.ps2d_in = ~(bus.ps2d_oe | bfm_d);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Wire-order frame from first principles: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Line monitor: clock-hold timing, start-bit timing, pulse exclusivity and line release.
  initial begin
    int  c_run = 0;
    logic prev_c = 1'b0;
    logic prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        c_run  = 0;
        prev_c = 1'b0;
        prev_d = 1'b0;
      end else begin
        if (bus.ps2c_oe && bus.ps2d_oe && !prev_d)
          check("start_bit_after_inhibit", 32'(c_run), 32'(INH));
        if (!bus.ps2c_oe && prev_c) begin
          check("clock_hold_len", 32'(c_run), 32'(INH + RTS));
          c_run = 0;
        end
        if (bus.ps2c_oe) c_run++;
        if (bus.done || bus.err) begin
          check("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
          check("idle_at_pulse", 32'({bus.busy, bus.ps2c_oe, bus.ps2d_oe}), 32'd0);
        end
        if (bus.done) done_cnt++;
        if (bus.err) begin
          err_cnt++;
          err_cyc = cyc;
        end
        prev_c = bus.ps2c_oe;
        prev_d = bus.ps2d_oe;
      end
    end
  end

  task automatic start_tx(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Device side: sample the start bit at clock release, then clock nclk bits, ACK on the 11th.
  task automatic bfm_xfer(input bit ack, input int nclk, output logic [10:0] got, output bit ok);
    int t = 0;
    got = '1;
    ok  = 1'b1;
    while (!bus.ps2c_oe && t < 200) begin @(negedge clk); t++; end
    t = 0;
    while (bus.ps2c_oe && t < INH + RTS + 200) begin @(negedge clk); t++; end
    if (bus.ps2c_oe || t == 0) begin
      ok = 1'b0;
      return;
    end
    got[0] = bus.ps2d_in;
    repeat ($urandom_range(1, 60)) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) begin
        bfm_d = 1'b1;
        repeat (5) @(negedge clk);
      end
      bfm_c     = 1'b1;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      if (i <= 10) got[i] = bus.ps2d_in;
      bfm_c = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_d = 1'b0;
    end
  endtask

  task automatic wait_quiet(input string tag);
    int t = 0;
    #1;
    while (bus.busy && t < TMO + 500) begin @(negedge clk); #1; t++; end
    check({tag, "_busy_drops"}, 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_ok(input logic [7:0] b, input string tag, output logic [10:0] got);
    bit ok;
    int d0 = done_cnt;
    int e0 = err_cnt;
    start_tx(b);
    bfm_xfer(1'b1, 11, got, ok);
    check({tag, "_bfm_started"}, 32'(ok), 32'd1);
    check({tag, "_frame"}, 32'(got), 32'(model_frame(b)));
    wait_quiet(tag);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic run_fail(input logic [7:0] b, input int nclk, input string tag);
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt;
    int e0 = err_cnt;
    start_tx(b);
    bfm_xfer(1'b0, nclk, got, ok);
    check({tag, "_bfm_started"}, 32'(ok), 32'd1);
    wait_quiet(tag);
    check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'd1);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd0);
    check({tag, "_lines_released"}, 32'({bus.ps2c_oe, bus.ps2d_oe}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    bit ok;
    int d0, t;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({bus.busy, bus.done, bus.err, bus.ps2c_oe, bus.ps2d_oe}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    check("model_pin_ED", 32'(model_frame(PS2_CMD_SET_LEDS)), 32'(11'b111_1101_1010));
    check("model_pin_01", 32'(model_frame(8'h01)), 32'(11'b100_0000_0010));
    check("model_pin_FF", 32'(model_frame(PS2_CMD_RESET)), 32'(11'b111_1111_1110));

    run_ok(PS2_CMD_SET_LEDS, "t1_ed", got);
    run_ok(8'h01, "t2_01", got);
    check("t2_01_parity", 32'(got[9]), 32'd0);
    run_ok(PS2_CMD_RESET, "t2_ff", got);
    check("t2_ff_parity", 32'(got[9]), 32'd1);

    for (int n = 0; n < 4; n++) run_ok(8'($urandom), "rand", got);

    run_fail(8'($urandom), 11, "t3_noack");

    run_fail(8'h00, 4, "t4_stall");
    check_range("t4_timeout_latency", err_cyc - last_fall, TMO + 2, TMO + 4);

    // Reset mid-frame: after the 5th bit of 0x00 the host is pulling ps2d low.
    start_tx(8'h00);
    bfm_xfer(1'b0, 5, got, ok);
    check("t5_bfm_started", 32'(ok), 32'd1);
    check("t5_bit5_driven", 32'({bus.busy, bus.ps2d_oe}), 32'b11);
    #2 reset = 1'b0;
    #1 check("t5_async_release", 32'({bus.ps2c_oe, bus.ps2d_oe, bus.busy}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_ok(8'h55, "t5_55", got);

    // Second start while busy must not disturb the latched command.
    d0 = done_cnt;
    start_tx(PS2_CMD_ENABLE);
    repeat (10) @(negedge clk);
    start_tx(8'h00);
    bfm_xfer(1'b1, 11, got, ok);
    check("t6_bfm_started", 32'(ok), 32'd1);
    check("t6_frame", 32'(got), 32'(model_frame(PS2_CMD_ENABLE)));
    t = 0;
    while (!bus.done && t < 200) begin @(negedge clk); t++; end
    check("t6_done_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    start_tx(PS2_CMD_RESET);
    check("t6_restart_busy", 32'(bus.busy), 32'd1);
    bfm_xfer(1'b1, 11, got, ok);
    check("t6_restart_frame", 32'(got), 32'(model_frame(PS2_CMD_RESET)));
    wait_quiet("t6");
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
